shacc_collect: RTL
==================

Name: shacc_collect

Overview:
- Downstream consumer of the input/weight address generator.
- Takes the generator's per-step control (step, shift, MSB flags, accumulation-done) together with the bit-serial partial products returned by the MVP lanes one memory latency later.
- Performs signed shift-accumulate per lane and hands finished accumulator vectors to the output/writeback path over a valid/ready handshake with a 2-entry buffer.

Parameters:
- N, 64, number of MVP lanes (accumulators).
- BDIN, 8, per-lane partial-product width (unsigned popcount).
- BACC, 32, accumulator/result width per lane.
- LAT, 2, cycles from address issue to d_in arrival (>=1).

Ports:
- clk  input  1  clock
- clr  input  1  synchronous active-high reset
- step  input  1  address issued this cycle (generator enable)
- sh  input  1  shift-before-add for this step (generator sh_out)
- imsb  input  1  input-data address is on MSB plane
- wmsb  input  1  weight address is on MSB plane
- done  input  1  last step of accumulation (generator shacc_done)
- d_in  input  N*BDIN  lane partial products; lane k at [k*BDIN +: BDIN]; valid LAT cycles after its step
- out_data  output  N*BACC  result vector; lane k at [k*BACC +: BACC]
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- stall  output  1  buffer full; upstream must hold step low
- ovf  output  1  sticky: result dropped because buffer was full
- busy  output  1  control in flight in delay line or accumulation open

Behaviour:
- Ports clk and clr; one clock domain; clr synchronous, active-high, priority over all else.
- Reset values: every accumulator 0, delay line empty, buffer empty; out_valid=0, out_data=0, stall=0, ovf=0, busy=0.
- Delay line:
  - {step, sh, imsb, wmsb, done} sampled at cycle t passes through LAT register stages.
  - Delayed copies (suffix _d) align with d_in at cycle t+LAT.
  - sh, imsb, wmsb and done are ignored when step=0 (masked on entry).
- Per-lane update, when step_d=1, at the end of cycle t+LAT:
  - term = zero-extend(d_in lane) to BACC, negated (two's complement) when imsb_d XOR wmsb_d.
  - base = sh_d ? (acc << 1) : acc; shift truncates to BACC, MSB discarded.
  - nxt = base + term, modulo 2^BACC with no saturation.
- Accumulator commit:
  - done_d=0: acc <= nxt.
  - done_d=1: nxt is pushed into the output buffer and acc <= 0, so the next accumulation starts clean on the following step with no dead cycle.
  - step_d=0: accumulators hold.
- Latency: done sampled at t -> out_valid high at t+LAT+1 when the buffer was empty.
- Output buffer:
  - 2-entry FIFO, in-order.
  - Head drives out_data/out_valid; out_data holds its value while out_valid=1 and out_ready=0.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle are allowed at any occupancy, including full (occupancy unchanged).
- stall = (occupancy==2), registered from occupancy. Upstream deasserts step the cycle after stall rises. Dones already in the delay line still arrive.
- Overflow: push while occupancy==2 and no simultaneous pop -> result discarded, ovf <= 1 (sticky until clr), buffer contents untouched, acc still cleared.
- busy = any step bit in delay line OR any committed step since the last done_d. Cleared by clr.
- clr mid-accumulation: in-flight steps and partial sums are lost; first result after clr contains only steps issued after clr.

Test Plan (N=2, BDIN=8, BACC=16, LAT=2 unless noted):
- Single step: step=done=imsb=wmsb=1, d_in={7,5} at t+2, out_ready=1 -> out_valid=1 at t+3, lanes {7,5}, then out_valid=0.
- 2-bit signed:
  - Steps: (imsb=1, wmsb=0, d=3), then (sh=1, imsb=0, wmsb=0, d=2, done=1).
  - Required: lane = (-3<<1)+2 = 0xFFFC.
  - Also: both-MSB step with d=1 adds +1.
- Back-to-back: done on every step for 4 cycles, d=1,2,3,4, out_ready=1 -> results 1,2,3,4 on consecutive cycles with no bubble; acc never carries over.
- Backpressure:
  - out_ready=0, three single-step dones (d=9, 10, 11) -> stall=1 after second push.
  - Third result dropped, ovf=1.
  - Raising out_ready yields 9 then 10; ovf stays 1.
- Wrap: accumulate to 0x7FFF, then sh step with d=0 -> 0xFFFE; add d=3 -> 0x0001 at done; no flag raised.
- Reset mid-op: two steps accumulated (d=5, 6), clr for one cycle while a step is in the delay line, then one step with d=4 and done -> result 4; out_valid/ovf/busy/stall all 0 the cycle after clr.

Source files
------------

// File: rtl/shacc_collect.sv
// Shift-accumulate collector: aligns generator control with returned partial
// products, accumulates signed bit-serial products per lane and queues finished
// vectors in a 2-entry output buffer with a valid/ready handshake.
module shacc_collect #(
  parameter int unsigned N    = 64,
  parameter int unsigned BDIN = 8,
  parameter int unsigned BACC = 32,
  parameter int unsigned LAT  = 2
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            step,
  input  logic            sh,
  input  logic            imsb,
  input  logic            wmsb,
  input  logic            done,
  input  logic [N*BDIN-1:0] d_in,
  output logic [N*BACC-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            stall,
  output logic            ovf,
  output logic            busy
);

  // Control word layout inside the delay line.
  localparam int unsigned CStep = 4;
  localparam int unsigned CSh   = 3;
  localparam int unsigned CImsb = 2;
  localparam int unsigned CWmsb = 1;
  localparam int unsigned CDone = 0;

  logic [4:0]      ctl_in;
  logic [4:0]      ctl_q [LAT];
  logic            step_d, sh_d, neg_d, done_d;

  logic [BACC-1:0] acc_q  [N];
  logic [BACC-1:0] ext_w  [N];
  logic [BACC-1:0] term_w [N];
  logic [BACC-1:0] base_w [N];
  logic [BACC-1:0] nxt_w  [N];
  logic [N*BACC-1:0] push_data;

  logic            open_q;

  logic [N*BACC-1:0] mem_q [2];
  logic            rd_q, wr_q;
  logic [1:0]      cnt_q, cnt_d;
  logic            stall_q, ovf_q;
  logic            push, pop, full, push_ok, drop;
  logic            line_busy;

  // Mask qualifiers with step so idle cycles never leak stale flags downstream.
  assign ctl_in = step ? {1'b1, sh, imsb, wmsb, done} : 5'b0;

  // Delay line: control rides LAT stages to meet its d_in.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < LAT; i++) ctl_q[i] <= '0;
    end else begin
      ctl_q[0] <= ctl_in;
      for (int i = 1; i < LAT; i++) ctl_q[i] <= ctl_q[i-1];
    end
  end

  assign step_d = ctl_q[LAT-1][CStep];
  assign sh_d   = ctl_q[LAT-1][CSh];
  assign neg_d  = ctl_q[LAT-1][CImsb] ^ ctl_q[LAT-1][CWmsb];
  assign done_d = ctl_q[LAT-1][CDone];

  // Per-lane signed shift-add; wraps modulo 2^BACC.
  always_comb begin
    push_data = '0;
    for (int k = 0; k < N; k++) begin
      ext_w[k]  = BACC'(d_in[k*BDIN +: BDIN]);
      term_w[k] = neg_d ? ({BACC{1'b0}} - ext_w[k]) : ext_w[k];
      base_w[k] = sh_d ? {acc_q[k][BACC-2:0], 1'b0} : acc_q[k];
      nxt_w[k]  = base_w[k] + term_w[k];
      push_data[k*BACC +: BACC] = nxt_w[k];
    end
  end

  // Accumulators: commit on step, restart from zero when the result leaves.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < N; k++) acc_q[k] <= '0;
    end else if (step_d) begin
      for (int k = 0; k < N; k++) acc_q[k] <= done_d ? '0 : nxt_w[k];
    end
  end

  // Tracks an accumulation that has committed steps but not yet finished.
  always_ff @(posedge clk) begin
    if (clr) begin
      open_q <= 1'b0;
    end else if (step_d) begin
      open_q <= ~done_d;
    end
  end

  assign push    = step_d & done_d;
  assign out_valid = (cnt_q != 2'd0);
  assign pop     = out_valid & out_ready;
  assign full    = (cnt_q == 2'd2);
  // A pop frees the head slot, so a full buffer can still take a push that cycle.
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  // Occupancy next-state.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Output buffer storage, pointers, stall and sticky overflow.
  always_ff @(posedge clk) begin
    if (clr) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
      stall_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q   <= cnt_d;
      stall_q <= (cnt_d == 2'd2);
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign out_data = out_valid ? mem_q[rd_q] : '0;
  assign stall    = stall_q;
  assign ovf      = ovf_q;

  // Any step still travelling toward its data keeps the block busy.
  always_comb begin
    line_busy = 1'b0;
    for (int i = 0; i < LAT; i++) line_busy = line_busy | ctl_q[i][CStep];
  end

  assign busy = line_busy | open_q;

endmodule
